id_ex_pipe: RTL

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with register-file write-back bypass, load-use
// hazard detection and a saturating count of the bubbles it inserts.
module id_ex_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             Valid_i,
   input  logic             Flush_i,
   input  logic [4:0]       RSaddr_i,
   input  logic [4:0]       RTaddr_i,
   input  logic [4:0]       RDaddr_i,
   input  logic [31:0]      RSdata_i,
   input  logic [31:0]      RTdata_i,
   input  logic [31:0]      Imm_i,
   input  logic [5:0]       Funct_i,
   input  logic             RegWrite_i,
   input  logic             MemtoReg_i,
   input  logic             MemRead_i,
   input  logic             MemWrite_i,
   input  logic             ALUSrc_i,
   input  logic             RegDst_i,
   input  logic [1:0]       ALUOp_i,
   input  logic             WB_RegWrite_i,
   input  logic [4:0]       WB_RDaddr_i,
   input  logic [31:0]      WB_RDdata_i,
   output logic             Valid_o,
   output logic [31:0]      RSdata_o,
   output logic [31:0]      RTdata_o,
   output logic [31:0]      Imm_o,
   output logic [5:0]       Funct_o,
   output logic [4:0]       RSaddr_o,
   output logic [4:0]       RTaddr_o,
   output logic [4:0]       Dest_o,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             ALUSrc_o,
   output logic [1:0]       ALUOp_o,
   output logic             Stall_o,
   output logic [CNT_W-1:0] BubbleCnt_o
);

   logic [31:0] rs_sel;
   logic [31:0] rt_sel;
   logic [4:0]  dest_sel;
   logic        rt_used;
   logic        bubble;

   // The register file returns the old value during a same-cycle write, so
   // the write port is bypassed here; register 0 always reads as zero.
   always_comb begin
      rs_sel = RSdata_i;
      if (RSaddr_i == 5'd0)
         rs_sel = 32'h0;
      else if (WB_RegWrite_i && (WB_RDaddr_i == RSaddr_i))
         rs_sel = WB_RDdata_i;
   end

   always_comb begin
      rt_sel = RTdata_i;
      if (RTaddr_i == 5'd0)
         rt_sel = 32'h0;
      else if (WB_RegWrite_i && (WB_RDaddr_i == RTaddr_i))
         rt_sel = WB_RDdata_i;
   end

   assign dest_sel = RegDst_i ? RDaddr_i : RTaddr_i;

   // RT is a real source for R-type ops and for stores (store data).
   assign rt_used = !ALUSrc_i || MemWrite_i;

   assign Stall_o = Valid_i && Valid_o && MemRead_o && (Dest_o != 5'd0) &&
                    ((Dest_o == RSaddr_i) || (rt_used && (Dest_o == RTaddr_i)));

   assign bubble = Flush_i || Stall_o;

   // NOTE: every register below uses <= so Stall_o, which reads the current
   // outputs, always sees pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i || bubble) begin
         Valid_o    <= 1'b0;
         RSdata_o   <= 32'h0;
         RTdata_o   <= 32'h0;
         Imm_o      <= 32'h0;
         Funct_o    <= 6'h0;
         RSaddr_o   <= 5'd0;
         RTaddr_o   <= 5'd0;
         Dest_o     <= 5'd0;
         RegWrite_o <= 1'b0;
         MemtoReg_o <= 1'b0;
         MemRead_o  <= 1'b0;
         MemWrite_o <= 1'b0;
         ALUSrc_o   <= 1'b0;
         ALUOp_o    <= 2'b00;
      end else begin
         Valid_o    <= Valid_i;
         RSdata_o   <= rs_sel;
         RTdata_o   <= rt_sel;
         Imm_o      <= Imm_i;
         Funct_o    <= Funct_i;
         RSaddr_o   <= RSaddr_i;
         RTaddr_o   <= RTaddr_i;
         Dest_o     <= dest_sel;
         // An empty slot must not write the register file or memory.
         RegWrite_o <= Valid_i && RegWrite_i;
         MemtoReg_o <= Valid_i && MemtoReg_i;
         MemRead_o  <= Valid_i && MemRead_i;
         MemWrite_o <= Valid_i && MemWrite_i;
         ALUSrc_o   <= ALUSrc_i;
         ALUOp_o    <= ALUOp_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         BubbleCnt_o <= '0;
      else if (bubble && Valid_i && (BubbleCnt_o != {CNT_W{1'b1}}))
         BubbleCnt_o <= BubbleCnt_o + 1'b1;
   end

endmodule
